// File: rtl/pipe_elastic_buffer.sv
// -----------------------------------------------------------------------------
// pipe_elastic_buffer
//
// DEPTH-entry elastic FIFO stage placed between two pipeline stages. It keeps
// the valid/allow interlock of a single-entry stage register, adds decoupling
// slack, and gives precise exceptions: when an entry whose sideband bit 0
// (is_exc) is set leaves the buffer, every younger entry is discarded and
// squash pulses for one cycle.
//
// Parameters
//   WIDTH        payload width
//   CSR_WIDTH    sideband width, bit 0 = is_exc
//   DEPTH        number of entries (>= 1, any value)
//   RESET_VALUE  payload loaded into all entries and the hold register on
//                reset or flush
//   HOLD_LAST    1: data_out shows the last issued payload while empty,
//                0: data_out shows nop_data while empty
//
// Ports
//   aclk        clock
//   areset      synchronous active-high reset
//   valid_in    upstream entry valid
//   data_in     upstream payload
//   csr_in      upstream sideband
//   allow_out   buffer can accept this cycle
//   ready_go    head may leave this cycle (0 = stall)
//   allow_in    downstream accepts
//   flush       discard all entries
//   nop_data    payload driven while empty (HOLD_LAST = 0)
//   valid_out   head valid and ready_go
//   data_out    head payload
//   csr_out     head sideband, 0 when empty
//   count       occupancy
//   squash      one-cycle pulse after an exception pop discarded the buffer
//
// Build option
//   PIPE_ELASTIC_BYPASS_EN  when defined, an entry arriving at an empty buffer
//   with ready_go and allow_in high passes straight through in the same cycle
//   and is not stored.
// -----------------------------------------------------------------------------
module pipe_elastic_buffer #(
  parameter int               WIDTH       = 64,
  parameter int               CSR_WIDTH   = 32,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               HOLD_LAST   = 1'b0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         valid_in,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [CSR_WIDTH-1:0]         csr_in,
  output logic                         allow_out,
  input  logic                         ready_go,
  input  logic                         allow_in,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             nop_data,
  output logic                         valid_out,
  output logic [WIDTH-1:0]             data_out,
  output logic [CSR_WIDTH-1:0]         csr_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         squash
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // storage
  logic [WIDTH-1:0]     data_q [DEPTH];
  logic [CSR_WIDTH-1:0] csr_q  [DEPTH];

  // control state
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] hold_q,   hold_d;
  logic             squash_q, squash_d;

  logic             head_valid;
  logic             head_exc;
  logic             bypass;
  logic             pop;
  logic             push;
  logic             store;
  logic             mem_we;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign head_valid = (count_q != '0);
  assign head_exc   = head_valid && csr_q[rd_ptr_q][0];

`ifdef PIPE_ELASTIC_BYPASS_EN
  assign bypass = !head_valid && valid_in && ready_go && allow_in;
`else
  assign bypass = 1'b0;
`endif

  // pop only ever refers to a stored head; a bypassed entry is never stored.
  assign pop       = head_valid && ready_go && allow_in;
  assign allow_out = (count_q < CNT_FULL) || pop;
  assign push      = valid_in && allow_out;
  assign store     = push && !bypass;
  assign valid_out = (head_valid && ready_go) || bypass;

  always_comb begin
    data_out = nop_data;
    csr_out  = '0;
    if (head_valid) begin
      data_out = data_q[rd_ptr_q];
      csr_out  = csr_q[rd_ptr_q];
    end else if (bypass) begin
      data_out = data_in;
      csr_out  = csr_in;
    end else if (HOLD_LAST) begin
      data_out = hold_q;
    end
  end

  assign count  = count_q;
  assign squash = squash_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    squash_d = 1'b0;
    mem_we   = 1'b0;

    if (areset || flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      hold_d   = RESET_VALUE;
    end else if (pop && head_exc) begin
      // The excepting head is delivered this cycle; everything behind it,
      // including a simultaneous push, is dropped. Realign rd to wr so the
      // empty buffer restarts from a consistent place.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      hold_d   = data_q[rd_ptr_q];
      squash_d = 1'b1;
    end else begin
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (store) begin
        mem_we   = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (store && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !store) begin
        count_d = count_q - CW'(1);
      end
      // A bypassed entry is issued too, so it also becomes the held payload.
      if (pop || bypass) begin
        hold_d = data_out;
      end
    end
  end

  always_ff @(posedge aclk) begin
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
    hold_q   <= hold_d;
    squash_q <= squash_d;
    if (areset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
        csr_q[i]  <= '0;
      end
    end else if (mem_we) begin
      data_q[wr_ptr_q] <= data_in;
      csr_q[wr_ptr_q]  <= csr_in;
    end
  end

endmodule

// File: tb/tb_pipe_elastic_buffer.sv
module tb_pipe_elastic_buffer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        valid_in;
  logic [63:0] data_in;
  logic [31:0] csr_in;
  logic        ready_go;
  logic        allow_in;
  logic        flush;
  logic [63:0] nop_data;

  logic        ao0, ao1, ao2;
  logic        vo0, vo1, vo2;
  logic [63:0] do0, do1, do2;
  logic [31:0] co0, co1, co2;
  logic [1:0]  cnt0;
  logic [2:0]  cnt1;
  logic [1:0]  cnt2;
  logic        sq0, sq1, sq2;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  pipe_elastic_buffer #(.DEPTH(2)) u_d2 (
    .aclk(aclk), .areset(areset), .valid_in(valid_in), .data_in(data_in),
    .csr_in(csr_in), .allow_out(ao0), .ready_go(ready_go), .allow_in(allow_in),
    .flush(flush), .nop_data(nop_data), .valid_out(vo0), .data_out(do0),
    .csr_out(co0), .count(cnt0), .squash(sq0)
  );

  pipe_elastic_buffer #(.DEPTH(4)) u_d4 (
    .aclk(aclk), .areset(areset), .valid_in(valid_in), .data_in(data_in),
    .csr_in(csr_in), .allow_out(ao1), .ready_go(ready_go), .allow_in(allow_in),
    .flush(flush), .nop_data(nop_data), .valid_out(vo1), .data_out(do1),
    .csr_out(co1), .count(cnt1), .squash(sq1)
  );

  pipe_elastic_buffer #(.DEPTH(3), .HOLD_LAST(1'b1)) u_d3 (
    .aclk(aclk), .areset(areset), .valid_in(valid_in), .data_in(data_in),
    .csr_in(csr_in), .allow_out(ao2), .ready_go(ready_go), .allow_in(allow_in),
    .flush(flush), .nop_data(nop_data), .valid_out(vo2), .data_out(do2),
    .csr_out(co2), .count(cnt2), .squash(sq2)
  );

  // Reference model: each instance is an ordered list, head at index 0.
  logic [63:0] mdat  [3][8];
  logic [31:0] mcsr  [3][8];
  int          msz   [3];
  logic [63:0] mhold [3];
  logic        msq   [3];
  int          mdep  [3];
  bit          mhl   [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void mexp(input int k, output logic v, output logic a,
                               output logic [63:0] d, output logic [31:0] c);
    v = (msz[k] != 0) && ready_go;
    a = (msz[k] < mdep[k]) || (v && allow_in);
    d = (msz[k] != 0) ? mdat[k][0] : (mhl[k] ? mhold[k] : nop_data);
    c = (msz[k] != 0) ? mcsr[k][0] : 32'h0;
  endfunction

  task automatic mstep(input int k);
    logic v, a, pop, push, exc;
    logic [63:0] d;
    logic [31:0] c;
    mexp(k, v, a, d, c);
    exc = 1'b0;
    if (areset || flush) begin
      msz[k]   = 0;
      mhold[k] = 64'h0;
      msq[k]   = 1'b0;
    end else begin
      pop    = v && allow_in;
      push   = valid_in && a;
      msq[k] = 1'b0;
      if (pop) begin
        mhold[k] = d;
        exc      = c[0];
        for (int i = 0; i < 7; i++) begin
          mdat[k][i] = mdat[k][i+1];
          mcsr[k][i] = mcsr[k][i+1];
        end
        msz[k]--;
        if (exc) begin
          msz[k] = 0;
          msq[k] = 1'b1;
          push   = 1'b0;
        end
      end
      if (push) begin
        mdat[k][msz[k]] = data_in;
        mcsr[k][msz[k]] = csr_in;
        msz[k]++;
      end
    end
  endtask

  task automatic cmp_all();
    logic v, a, ov, oa, os;
    logic [63:0] d, od;
    logic [31:0] c, oc;
    int on;
    for (int k = 0; k < 3; k++) begin
      mexp(k, v, a, d, c);
      case (k)
        0:       begin ov = vo0; oa = ao0; od = do0; oc = co0; on = int'(cnt0); os = sq0; end
        1:       begin ov = vo1; oa = ao1; od = do1; oc = co1; on = int'(cnt1); os = sq1; end
        default: begin ov = vo2; oa = ao2; od = do2; oc = co2; on = int'(cnt2); os = sq2; end
      endcase
      chk($sformatf("i%0d valid_out", k), 64'(ov), 64'(v));
      chk($sformatf("i%0d allow_out", k), 64'(oa), 64'(a));
      chk($sformatf("i%0d data_out", k), od, d);
      chk($sformatf("i%0d csr_out", k), 64'(oc), 64'(c));
      chk($sformatf("i%0d count", k), 64'(on), 64'(msz[k]));
      chk($sformatf("i%0d squash", k), 64'(os), 64'(msq[k]));
    end
  endtask

  task automatic step();
    #1 cmp_all();
    @(posedge aclk);
    for (int k = 0; k < 3; k++) mstep(k);
    @(negedge aclk);
  endtask

  initial begin
    mdep[0] = 2; mdep[1] = 4; mdep[2] = 3;
    mhl[0]  = 0; mhl[1]  = 0; mhl[2]  = 1;
    for (int k = 0; k < 3; k++) begin
      msz[k] = 0; mhold[k] = 64'h0; msq[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mdat[k][i] = 64'h0; mcsr[k][i] = 32'h0;
      end
    end

    areset = 1'b1; valid_in = 1'b0; data_in = 64'h0; csr_in = 32'h0;
    ready_go = 1'b1; allow_in = 1'b0; flush = 1'b0; nop_data = 64'hDEAD;
    @(negedge aclk);

    // reset held two cycles
    step(); step();
    areset = 1'b0;
    step();
    chk("reset count", 64'(cnt0), 64'd0);
    chk("reset valid_out", 64'(vo0), 64'd0);
    chk("reset allow_out", 64'(ao0), 64'd1);
    chk("reset data_out nop", do0, 64'hDEAD);
    chk("reset data_out hold_last", do2, 64'h0);

    // fill DEPTH=2 with downstream blocked
    valid_in = 1'b1; allow_in = 1'b0;
    data_in = 64'h11; step();
    data_in = 64'h22; step();
    chk("fill count", 64'(cnt0), 64'd2);
    chk("fill allow_out full", 64'(ao0), 64'd0);
    // full with simultaneous pop and push
    data_in = 64'h33; allow_in = 1'b1;
    #1;
    chk("full pop head", do0, 64'h11);
    chk("full allow_out with pop", 64'(ao0), 64'd1);
    step();
    chk("full count stays", 64'(cnt0), 64'd2);

    // stall three cycles
    valid_in = 1'b0; ready_go = 1'b0;
    repeat (3) begin
      step();
      chk("stall valid_out", 64'(vo0), 64'd0);
      chk("stall data_out", do0, 64'h22);
    end
    ready_go = 1'b1;
    step();
    chk("drain second", do0, 64'h33);
    step();
    chk("drain count", 64'(cnt0), 64'd0);
    chk("drain nop", do0, 64'hDEAD);

    // exception squash
    valid_in = 1'b1; allow_in = 1'b0;
    data_in = 64'hA; csr_in = 32'h1; step();
    data_in = 64'hB; csr_in = 32'h0; step();
    data_in = 64'hC; step();
    chk("exc fill count d4", 64'(cnt1), 64'd3);
    data_in = 64'hD; allow_in = 1'b1;
    #1;
    chk("exc head data", do1, 64'hA);
    chk("exc head csr", 64'(co1), 64'd1);
    step();
    chk("exc count cleared", 64'(cnt1), 64'd0);
    chk("exc squash pulse", 64'(sq1), 64'd1);
    valid_in = 1'b0;
    step();
    chk("exc squash ends", 64'(sq1), 64'd0);
    chk("exc nothing after", 64'(vo1), 64'd0);

    // flush against push and pop
    valid_in = 1'b1; allow_in = 1'b0;
    data_in = 64'h55; step();
    data_in = 64'h66; step();
    flush = 1'b1; data_in = 64'h77; allow_in = 1'b1;
    step();
    flush = 1'b0; valid_in = 1'b0;
    step();
    chk("flush count", 64'(cnt0), 64'd0);
    chk("flush valid_out", 64'(vo0), 64'd0);
    chk("flush hold reset", do2, 64'h0);
    step();
    chk("flush stays empty", 64'(vo1), 64'd0);

    // continuous stream across pointer wrap
    valid_in = 1'b1; allow_in = 1'b1; ready_go = 1'b1; csr_in = 32'h0;
    for (int i = 0; i < 10; i++) begin
      data_in = 64'h100 + 64'(i);
      step();
    end
    valid_in = 1'b0;
    repeat (3) step();
    chk("hold_last keeps last", do2, 64'h109);
    chk("hold_last empty", 64'(cnt2), 64'd0);
    chk("no hold_last nop", do0, 64'hDEAD);

    // randomized traffic
    repeat (400) begin
      areset   = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 31) == 0);
      valid_in = ($urandom_range(0, 3) != 0);
      ready_go = ($urandom_range(0, 4) != 0);
      allow_in = ($urandom_range(0, 3) != 0);
      data_in  = {$urandom, $urandom};
      csr_in   = $urandom;
      csr_in[0] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) nop_data = {$urandom, $urandom};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_elastic_buffer.md
Name: pipe_elastic_buffer

Overview:
- Parametrised successor to the single-entry inter-stage pipeline register.
- DEPTH-entry elastic FIFO stage with the same valid/allow interlock, ready_go stall, flush and nop-on-empty output.
- Each entry carries a CSR sideband with an exception bit. When an excepting entry issues, all younger entries are squashed, which gives a precise exception.
- Sits between any two pipeline stages (e.g. IF->ID, ID->EX) where decoupling or prefetch slack is needed.

Parameters:
- WIDTH, 64, payload width in bits.
- CSR_WIDTH, 32, sideband width; bit 0 is is_exc.
- DEPTH, 2, number of entries (>=1, power of two not required).
- RESET_VALUE, 0, payload value loaded into all entries and the hold register on reset or flush.
- HOLD_LAST, 0, when 1, the output keeps the last issued payload while empty instead of nop_data (PC-stage usage).

Ports:
- aclk, input, 1, clock.
- areset, input, 1, synchronous active-high reset.
- valid_in, input, 1, upstream entry valid.
- data_in, input, WIDTH, upstream payload.
- csr_in, input, CSR_WIDTH, upstream sideband; bit 0 = is_exc.
- allow_out, output, 1, buffer can accept this cycle.
- ready_go, input, 1, head may leave this cycle (0 = stall).
- allow_in, input, 1, downstream accepts.
- flush, input, 1, discard all entries.
- nop_data, input, WIDTH, payload driven when empty.
- valid_out, output, 1, head valid and ready_go.
- data_out, output, WIDTH, head payload.
- csr_out, output, CSR_WIDTH, head sideband; 0 when empty.
- count, output, $clog2(DEPTH+1), occupancy.
- squash, output, 1, one-cycle pulse when an exception pop discarded younger entries.

Behaviour:
- Storage is a circular buffer with rd_ptr, wr_ptr (mod DEPTH) and count.
- pop = valid_out && allow_in.
- push = valid_in && allow_out.
- allow_out = (count < DEPTH) || pop. The combinational allow_in->allow_out path is permitted, as in the existing stage register.
- valid_out = (count != 0) && ready_go.
- Latency is 1 cycle minimum from push to valid_out; full throughput is 1 entry/cycle.
- data_out = head payload when count != 0. When empty: hold register if HOLD_LAST, else nop_data.
- csr_out = head sideband when count != 0, else 0.
- Hold register loads the popped payload on every pop.
- Priority per cycle, highest first:
  1. areset or flush: count=0, rd_ptr=wr_ptr=0, hold=RESET_VALUE, squash=0. Any push or pop in that cycle is discarded.
  2. Pop of a head with csr bit 0 set: count=0, pointers realigned (rd_ptr=wr_ptr), a simultaneous push is dropped, squash=1 next cycle. The excepting entry itself is delivered.
  3. Otherwise push and pop are independent: count += push - pop.
- Full and simultaneous pop+push: accepted, count stays DEPTH.
- Empty and push: entry visible next cycle; no same-cycle pass-through unless the optional feature is compiled in.
- Pointer wrap: incrementing at DEPTH-1 goes to 0, including non-power-of-two DEPTH.
- ready_go=0 freezes the head; pushes continue until full.
- Reset values: valid_out=0, allow_out=1, count=0, squash=0, csr_out=0, data_out = nop_data (RESET_VALUE if HOLD_LAST).
- Entries are never written when push=0. Payload of invalid slots is don't-care but never visible.

Optional Feature:
- Macro: PIPE_ELASTIC_BYPASS_EN.
- Defined: when count==0, valid_in, ready_go and allow_in are all 1, data_in/csr_in drive data_out/csr_out combinationally. valid_out=1 and nothing is stored, giving 0-cycle latency. An is_exc bypass entry does not pulse squash, since nothing is buffered. If allow_in=0, the entry is stored normally.
- Undefined: minimum latency 1 cycle; valid_out depends only on stored state and ready_go.

Test Plan:
- Reset, DEPTH=2: hold areset 2 cycles -> count=0, valid_out=0, allow_out=1, data_out=nop_data=0xDEAD.
- Fill: push 0x11, 0x22 with allow_in=0 -> count=2, allow_out=0 once full. Push 0x33 with allow_in=1 in the same cycle -> 0x11 out, count stays 2, order 0x22 then 0x33.
- Stall: 2 entries held, ready_go=0 for 3 cycles -> valid_out=0, data_out=0x22 stable. ready_go=1 -> pops in order.
- Exception squash, DEPTH=4: push A (csr=1), B, C. Pop A while pushing D -> A delivered, next cycle count=0, squash=1 for one cycle, B/C/D never appear.
- Flush vs push: flush=1 with push and pop asserted -> next cycle count=0, valid_out=0, nothing issued after.
- Wrap / HOLD_LAST, DEPTH=3, HOLD_LAST=1: stream 10 entries continuous -> in-order delivery across wrap. After the last pop with empty buffer, data_out holds the last payload, not nop_data.
